vga_capture: RTL and testbench
==============================

Name: vga_capture

Overview:
- Receive side of the VGA link: digitises an external 640x480@60 VGA source.
- Recovers pixel coordinates from incoming hsync/vsync and the ADC pixel bus.
- Emits visible pixels with x/y and a valid strobe to the downstream frame writer.
- Tracks sync lock and counts sync errors.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch clocks
- H_SYNC, 96, hsync pulse clocks
- H_BACK, 48, horizontal back porch clocks
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch lines
- V_SYNC, 2, vsync pulse lines
- V_BACK, 33, vertical back porch lines
- SYNC_ACTIVE_LOW, 1, 1 = sync asserted when low
- SYNC_STAGES, 2, synchroniser flops on hsync/vsync (>=2)
- LOSS_MARGIN, 8, extra clocks past H_TOTAL before a missing hsync is an error

Ports:
- clk25  in  1  25 MHz pixel clock, same as ADC sample clock
- rst  in  1  asynchronous, active-high reset
- hw_adc_pixel  in  16  RGB565 sample from ADC
- hw_hsync_in  in  1  external hsync
- hw_vsync_in  in  1  external vsync
- pixel_out  out  16  captured visible pixel
- pixel_x  out  10  visible column 0..639
- pixel_y  out  10  visible row 0..479
- pixel_valid  out  1  pixel_out/x/y valid this cycle
- frame_start  out  1  1-cycle pulse with pixel (0,0)
- locked  out  1  sync timing verified
- sync_err_count  out  8  saturating sync error counter

Behaviour:
- Derived constants: H_TOTAL = sum of H terms (800); V_TOTAL = sum of V terms (525); H_START = H_SYNC+H_BACK (144); V_START = V_SYNC+V_BACK (35).
- Reset values: all outputs 0. Reset clears all counters and the FSM, with state = SEARCH. Reset mid-frame takes effect immediately (asynchronous); capture restarts from SEARCH.
- Sync inputs:
  - Polarity-normalised, then passed through SYNC_STAGES flops.
  - An assert edge is detected on the synchronised, normalised signal.
  - hw_adc_pixel is delayed by SYNC_STAGES+1 registers, so the sample coincident with the external hsync edge pairs with h_cnt=0.
- h_cnt (10 bit):
  - Set to 0 on an hsync assert edge; otherwise increments.
  - Saturates at 1023; no wrap.
- v_cnt (10 bit):
  - On a vsync assert edge, set to 0. This has priority when the vsync and hsync edges fall in the same cycle.
  - Otherwise increments on each hsync edge, saturating at 1023.
- Line check: at an hsync edge, the previous h_cnt must equal H_TOTAL-1. Timeout: h_cnt reaching H_TOTAL+LOSS_MARGIN without an edge is a line error.
- Frame check: at a vsync edge, the previous v_cnt must equal V_TOTAL-1.
- FSM:
  - SEARCH: wait for a vsync edge, then go to ACQUIRE. Line errors are not counted in SEARCH.
  - ACQUIRE: watch one full frame.
    - At the next vsync edge, if the frame check passed and no line error occurred, go to LOCKED.
    - Otherwise stay in ACQUIRE and restart the observation.
  - LOCKED: on any line error or frame-check failure, go to SEARCH and increment sync_err_count (saturates at 255).
- locked = 1 only in LOCKED. A registered output, high from the cycle after the qualifying vsync edge.
- Output stage, registered, 1 cycle after the counters:
  - pixel_valid = LOCKED and H_START <= h_cnt < H_START+H_VISIBLE and V_START <= v_cnt < V_START+V_VISIBLE.
  - pixel_x = h_cnt-H_START; pixel_y = v_cnt-V_START; pixel_out = aligned sample.
  - When pixel_valid = 0, pixel_out, pixel_x and pixel_y hold their last values.
  - frame_start = pixel_valid with x = 0 and y = 0.
- End-to-end latency: external edge to matching output is SYNC_STAGES+2 clocks.
- Losing lock mid-line: pixel_valid drops the cycle after the error is detected, and no partial frame_start occurs.

Test Plan:
- Reset, then drive 3 ideal 800x525 frames with active-low sync:
  - locked=0 through frame 1; locked rises after the 2nd vsync edge.
  - Frame 3 yields exactly 307200 pixel_valid cycles and one frame_start.
- Ramp data, with ADC sample = h index at each sync edge:
  - First valid pixel in a line has pixel_x=0 and pixel_out=144.
  - Last valid pixel has pixel_x=639 and pixel_out=783.
  - pixel_y runs 0..479.
- While locked, shorten one line to 799 clocks:
  - locked falls and pixel_valid falls the next cycle.
  - sync_err_count goes 0->1; relock occurs after 2 clean frames.
- While locked, remove hsync entirely: an error is flagged when h_cnt reaches 808, h_cnt saturates at 1023, and sync_err_count increments once.
- Frame of 524 lines: frame check fails, lock is lost, and the counter increments; in ACQUIRE, a 524-line frame keeps locked=0.
- Assert rst mid-visible-line: all outputs are 0 immediately. After release, locked=0 until 2 clean vsync edges.
- 300 forced errors: sync_err_count saturates at 255.

Source files
------------

// File: rtl/vga_capture.sv
// vga_capture: VGA receive front end.
// Recovers sync timing, locks, emits visible pixels.
module vga_capture #(
   parameter int H_VISIBLE       = 640,
   parameter int H_FRONT         = 16,
   parameter int H_SYNC          = 96,
   parameter int H_BACK          = 48,
   parameter int V_VISIBLE       = 480,
   parameter int V_FRONT         = 10,
   parameter int V_SYNC          = 2,
   parameter int V_BACK          = 33,
   parameter int SYNC_ACTIVE_LOW = 1,
   parameter int SYNC_STAGES     = 2,
   parameter int LOSS_MARGIN     = 8
) (
   input  logic        clk25,
   input  logic        rst,
   input  logic [15:0] hw_adc_pixel,
   input  logic        hw_hsync_in,
   input  logic        hw_vsync_in,
   output logic [15:0] pixel_out,
   output logic [9:0]  pixel_x,
   output logic [9:0]  pixel_y,
   output logic        pixel_valid,
   output logic        frame_start,
   output logic        locked,
   output logic [7:0]  sync_err_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int H_START = H_SYNC + H_BACK;
   localparam int V_START = V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_LOSS  = 10'(H_TOTAL + LOSS_MARGIN);
   localparam logic [9:0] H_BEG   = 10'(H_START);
   localparam logic [9:0] H_END   = 10'(H_START + H_VISIBLE);
   localparam logic [9:0] V_BEG   = 10'(V_START);
   localparam logic [9:0] V_END   = 10'(V_START + V_VISIBLE);
   localparam logic [9:0] CNT_MAX = 10'h3FF;

   typedef enum logic [1:0] {
      SEARCH,
      ACQUIRE,
      LOCKED
   } state_t;

   state_t state, state_nx;

   logic                   hs_norm, vs_norm;
   logic [SYNC_STAGES-1:0] hs_sync, vs_sync;
   logic                   hs_prev, vs_prev;
   logic                   hs_edge, vs_edge;
   logic [15:0]            pix_dly [SYNC_STAGES+1];
   logic [9:0]             h_cnt, v_cnt;
   logic                   line_err, frame_ok;
   logic                   err_seen, err_seen_nx;
   logic                   err_inc;
   logic                   in_win, vis;

   assign hs_norm = (SYNC_ACTIVE_LOW != 0) ? ~hw_hsync_in : hw_hsync_in;
   assign vs_norm = (SYNC_ACTIVE_LOW != 0) ? ~hw_vsync_in : hw_vsync_in;

   // Synchronise normalised sync inputs and keep last value for edges
   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         hs_sync <= '0;
         vs_sync <= '0;
         hs_prev <= 1'b0;
         vs_prev <= 1'b0;
      end else begin
         hs_sync <= {hs_sync[SYNC_STAGES-2:0], hs_norm};
         vs_sync <= {vs_sync[SYNC_STAGES-2:0], vs_norm};
         hs_prev <= hs_sync[SYNC_STAGES-1];
         vs_prev <= vs_sync[SYNC_STAGES-1];
      end
   end

   assign hs_edge = hs_sync[SYNC_STAGES-1] & ~hs_prev;
   assign vs_edge = vs_sync[SYNC_STAGES-1] & ~vs_prev;

   // Delay ADC samples so they line up with the recovered counters
   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= SYNC_STAGES; i++) pix_dly[i] <= '0;
      end else begin
         pix_dly[0] <= hw_adc_pixel;
         for (int i = 1; i <= SYNC_STAGES; i++) pix_dly[i] <= pix_dly[i-1];
      end
   end

   // Saturating horizontal and vertical position counters
   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         if (hs_edge)
            h_cnt <= '0;
         else if (h_cnt != CNT_MAX)
            h_cnt <= h_cnt + 10'd1;
         if (vs_edge)
            v_cnt <= '0;
         else if (hs_edge && v_cnt != CNT_MAX)
            v_cnt <= v_cnt + 10'd1;
      end
   end

   assign line_err = (hs_edge && h_cnt != H_LAST) ||
                     (!hs_edge && h_cnt == H_LOSS);
   assign frame_ok = (v_cnt == V_LAST);

   // Lock state, per-frame error flag, error counter and lock output
   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         state          <= SEARCH;
         err_seen       <= 1'b0;
         sync_err_count <= '0;
         locked         <= 1'b0;
      end else begin
         state    <= state_nx;
         err_seen <= err_seen_nx;
         locked   <= (state_nx == LOCKED);
         if (err_inc && sync_err_count != 8'hFF)
            sync_err_count <= sync_err_count + 8'd1;
      end
   end

   // Next-state: acquire watches one full frame, locked drops on any error
   always_comb begin
      state_nx    = state;
      err_seen_nx = err_seen;
      err_inc     = 1'b0;
      unique case (state)
         SEARCH: begin
            if (vs_edge) begin
               state_nx    = ACQUIRE;
               err_seen_nx = 1'b0;
            end
         end
         ACQUIRE: begin
            if (vs_edge) begin
               if (frame_ok && !err_seen && !line_err)
                  state_nx = LOCKED;
               err_seen_nx = 1'b0;
            end else if (line_err) begin
               err_seen_nx = 1'b1;
            end
         end
         LOCKED: begin
            if (line_err || (vs_edge && !frame_ok)) begin
               state_nx = SEARCH;
               err_inc  = 1'b1;
            end
         end
         default: state_nx = SEARCH;
      endcase
   end

   assign in_win = (h_cnt >= H_BEG) && (h_cnt < H_END) &&
                   (v_cnt >= V_BEG) && (v_cnt < V_END);
   assign vis    = (state_nx == LOCKED) && in_win;

   // Registered pixel output; data and position hold outside the window
   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         pixel_valid <= 1'b0;
         frame_start <= 1'b0;
         pixel_out   <= '0;
         pixel_x     <= '0;
         pixel_y     <= '0;
      end else begin
         pixel_valid <= vis;
         frame_start <= vis && (h_cnt == H_BEG) && (v_cnt == V_BEG);
         if (vis) begin
            pixel_out <= pix_dly[SYNC_STAGES];
            pixel_x   <= h_cnt - H_BEG;
            pixel_y   <= v_cnt - V_BEG;
         end
      end
   end

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: scoreboard bench for vga_capture.
// Uses a reduced raster so whole frames stay short.
module tb_vga_capture;

   localparam int HV = 8;
   localparam int HF = 2;
   localparam int HS = 2;
   localparam int HB = 2;
   localparam int VV = 3;
   localparam int VF = 1;
   localparam int VS = 1;
   localparam int VB = 1;
   localparam int LM = 8;
   localparam int HT  = HV + HF + HS + HB;
   localparam int VT  = VV + VF + VS + VB;
   localparam int HST = HS + HB;
   localparam int VST = VS + VB;

   logic        clk25 = 1'b0;
   logic        rst;
   logic [15:0] adc;
   logic        hs, vs;
   logic [15:0] pixel_out;
   logic [9:0]  pixel_x, pixel_y;
   logic        pixel_valid, frame_start, locked;
   logic [7:0]  sync_err_count;

   typedef struct packed {
      logic [15:0] d;
      logic [9:0]  x;
      logic [9:0]  y;
      logic        fs;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;
   int nvalid = 0;
   int nfs    = 0;

   always #20 clk25 = ~clk25;

   vga_capture #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .SYNC_ACTIVE_LOW(1), .SYNC_STAGES(2), .LOSS_MARGIN(LM)
   ) dut (
      .clk25(clk25),
      .rst(rst),
      .hw_adc_pixel(adc),
      .hw_hsync_in(hs),
      .hw_vsync_in(vs),
      .pixel_out(pixel_out),
      .pixel_x(pixel_x),
      .pixel_y(pixel_y),
      .pixel_valid(pixel_valid),
      .frame_start(frame_start),
      .locked(locked),
      .sync_err_count(sync_err_count)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk25);
         hs  = 1'b1;
         vs  = 1'b1;
         adc = '0;
      end
   endtask

   task automatic drive_line(input int len, input int line,
                             input bit push);
      exp_t e;
      for (int h = 0; h < len; h++) begin
         @(negedge clk25);
         hs  = !(h < HS);
         vs  = !(line < VS);
         adc = 16'((line << 10) | h);
         if (push && line >= VST && line < VST + VV &&
             h >= HST && h < HST + HV) begin
            e.d  = 16'((line << 10) | h);
            e.x  = 10'(h - HST);
            e.y  = 10'(line - VST);
            e.fs = (h == HST) && (line == VST);
            q.push_back(e);
         end
      end
   endtask

   task automatic drive_frame(input int nlines, input int short_idx,
                              input int valid_rows);
      for (int l = 0; l < nlines; l++)
         drive_line((l == short_idx) ? HT - 1 : HT, l,
                    l < VST + valid_rows);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk25);
         #1;
         if (pixel_valid) begin
            nvalid++;
            if (frame_start) nfs++;
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pixel: got x=%0d y=%0d expected none",
                        pixel_x, pixel_y);
            end else begin
               e = q.pop_front();
               if ({pixel_out, pixel_x, pixel_y, frame_start} !== e) begin
                  errors++;
                  $display("FAIL pixel: got d=%h x=%0d y=%0d fs=%b expected d=%h x=%0d y=%0d fs=%b",
                           pixel_out, pixel_x, pixel_y, frame_start,
                           e.d, e.x, e.y, e.fs);
               end
            end
         end else if (frame_start) begin
            checks++;
            errors++;
            $display("FAIL stray_frame_start: got 1 expected 0");
         end
      end
   end

   initial begin : stim
      rst = 1'b1;
      hs  = 1'b1;
      vs  = 1'b1;
      adc = '0;
      repeat (3) @(negedge clk25);
      chk("rst_valid", pixel_valid, 0);
      chk("rst_locked", locked, 0);
      chk("rst_errcnt", sync_err_count, 0);
      chk("rst_pixel", pixel_out, 0);
      rst = 1'b0;
      idle(20);

      drive_frame(VT, -1, 0);
      chk("f1_locked", locked, 0);
      drive_frame(VT, -1, VV);
      chk("f2_locked", locked, 1);
      nvalid = 0;
      nfs    = 0;
      drive_frame(VT, -1, VV);
      chk("f3_nvalid", nvalid, HV * VV);
      chk("f3_nfs", nfs, 1);
      chk("f3_drained", q.size(), 0);

      drive_frame(VT, 3, 2);
      chk("short_locked", locked, 0);
      chk("short_errcnt", sync_err_count, 1);
      chk("short_drained", q.size(), 0);
      drive_frame(VT, -1, 0);
      chk("relock1_locked", locked, 0);
      drive_frame(VT, -1, VV);
      chk("relock2_locked", locked, 1);

      idle(12);
      chk("loss_before", locked, 1);
      idle(1);
      chk("loss_after", locked, 0);
      chk("loss_errcnt", sync_err_count, 2);
      idle(1100);
      chk("loss_hsat", dut.h_cnt, 1023);
      chk("loss_errcnt_once", sync_err_count, 2);
      drive_frame(VT, -1, 0);
      chk("loss_acq_locked", locked, 0);
      drive_frame(VT, -1, VV);
      chk("loss_relock", locked, 1);

      drive_frame(VT - 1, -1, VV);
      drive_frame(VT, -1, 0);
      chk("vshort_locked", locked, 0);
      chk("vshort_errcnt", sync_err_count, 3);
      drive_frame(VT - 1, -1, 0);
      drive_frame(VT, -1, 0);
      chk("vshort_acq_locked", locked, 0);
      drive_frame(VT, -1, VV);
      chk("vshort_relock", locked, 1);
      chk("vshort_errcnt2", sync_err_count, 3);

      drive_line(HT, 0, 1'b1);
      drive_line(HT, 1, 1'b1);
      drive_line(HST + 6, 2, 1'b1);
      chk("prerst_valid", pixel_valid, 1);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_valid", pixel_valid, 0);
      chk("midrst_locked", locked, 0);
      chk("midrst_x", pixel_x, 0);
      chk("midrst_pixel", pixel_out, 0);
      chk("midrst_errcnt", sync_err_count, 0);
      q.delete();
      idle(5);
      rst = 1'b0;
      idle(10);
      drive_frame(VT, -1, 0);
      chk("postrst_locked1", locked, 0);
      drive_frame(VT, -1, VV);
      chk("postrst_locked2", locked, 1);

      for (int i = 1; i <= 260; i++) begin
         drive_frame(VT, 0, 0);
         drive_frame(VT, -1, 0);
         if (i == 100) chk("sat_errcnt100", sync_err_count, 100);
         if (i == 255) chk("sat_errcnt255", sync_err_count, 255);
      end
      chk("sat_errcnt_final", sync_err_count, 255);
      drive_frame(VT, -1, VV);
      chk("final_locked", locked, 1);
      idle(20);
      chk("final_drained", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
